// File: rtl/dma_read_control.sv
`default_nettype none
// ============================================================================
// Module   : dma_read_control
// Brief    : AXI4 read master that fetches a byte range in 4 KB-safe bursts
//            and forwards every beat unbuffered onto an AXI-Stream master.
// Revision : 1.0  initial release
// ============================================================================
module dma_read_control #(
    parameter int MAX_BURST = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] dma_sa_config,
    input  logic [25:0] dma_length_config,
    input  logic        dma_read_valid,
    output logic        dma_read_idle,
    output logic        DMA_Read_INT,
    output logic        dma_read_error,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [23:0] C_MAX_BURST  = 24'(MAX_BURST);
    localparam logic [23:0] C_PAGE_BEATS = 24'd1024;

    state_t      r_state_q,  w_state_d;
    logic [31:0] r_addr_q,   w_addr_d;
    logic [23:0] r_remain_q, w_remain_d;
    logic [4:0]  r_burst_q,  w_burst_d;
    logic        r_error_q,  w_error_d;

    logic [23:0] w_to_page;
    logic [23:0] w_beats;
    logic        w_beat;
    logic        w_unused;

    // The beat counter alone closes a burst, so rlast and the byte-lane bits carry no information.
    assign w_unused = &{1'b0, m_axi_rlast, dma_sa_config[1:0], dma_length_config[1:0]};

    assign w_to_page = C_PAGE_BEATS - {14'd0, r_addr_q[11:2]};

    always_comb begin
        w_beats = r_remain_q;
        if (w_beats > C_MAX_BURST) w_beats = C_MAX_BURST;
        if (w_beats > w_to_page)   w_beats = w_to_page;
    end

    assign w_beat = (r_state_q == S_DATA) && m_axi_rvalid && m_axis_tready;

    assign dma_read_idle  = (r_state_q == S_IDLE);
    assign DMA_Read_INT   = (r_state_q == S_DONE);
    assign dma_read_error = r_error_q;

    assign m_axi_araddr  = r_addr_q;
    assign m_axi_arlen   = (r_state_q == S_ADDR) ? 8'(w_beats - 24'd1) : 8'd0;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (r_state_q == S_ADDR);

    assign m_axi_rready  = (r_state_q == S_DATA) && m_axis_tready;
    assign m_axis_tvalid = (r_state_q == S_DATA) && m_axi_rvalid;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = (r_state_q == S_DATA) && (r_remain_q == 24'd1);

    always_comb begin
        w_state_d  = r_state_q;
        w_addr_d   = r_addr_q;
        w_remain_d = r_remain_q;
        w_burst_d  = r_burst_q;
        w_error_d  = r_error_q;
        case (r_state_q)
            S_IDLE: begin
                if (dma_read_valid) begin
                    w_addr_d   = {dma_sa_config[31:2], 2'b00};
                    w_remain_d = dma_length_config[25:2];
                    w_error_d  = 1'b0;
                    w_state_d  = (dma_length_config[25:2] != 24'd0) ? S_ADDR : S_DONE;
                end
            end
            S_ADDR: begin
                if (m_axi_arready) begin
                    w_burst_d = w_beats[4:0];
                    w_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_beat) begin
                    // Advancing per beat leaves the next burst address ready when the burst ends.
                    w_addr_d   = r_addr_q + 32'd4;
                    w_remain_d = r_remain_q - 24'd1;
                    w_burst_d  = r_burst_q - 5'd1;
                    if (m_axi_rresp != 2'b00) w_error_d = 1'b1;
                    if (r_burst_q == 5'd1) begin
                        w_state_d = (r_remain_q == 24'd1) ? S_DONE : S_ADDR;
                    end
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q  <= S_IDLE;
            r_addr_q   <= 32'd0;
            r_remain_q <= 24'd0;
            r_burst_q  <= 5'd0;
            r_error_q  <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_addr_q   <= w_addr_d;
            r_remain_q <= w_remain_d;
            r_burst_q  <= w_burst_d;
            r_error_q  <= w_error_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_read_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_read_control
// Brief    : Randomised self-checking bench for dma_read_control with an AXI
//            read-slave memory model and a burst-splitting reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dma_read_control;

    localparam int MAX_BURST = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dma_sa_config;
    logic [25:0] dma_length_config;
    logic        dma_read_valid;
    logic        dma_read_idle;
    logic        DMA_Read_INT;
    logic        dma_read_error;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    always #5 clk = ~clk;

    dma_read_control #(.MAX_BURST(MAX_BURST)) dut (
        .CLK               (clk),
        .RST               (rst),
        .dma_sa_config     (dma_sa_config),
        .dma_length_config (dma_length_config),
        .dma_read_valid    (dma_read_valid),
        .dma_read_idle     (dma_read_idle),
        .DMA_Read_INT      (DMA_Read_INT),
        .dma_read_error    (dma_read_error),
        .m_axi_araddr      (m_axi_araddr),
        .m_axi_arlen       (m_axi_arlen),
        .m_axi_arsize      (m_axi_arsize),
        .m_axi_arburst     (m_axi_arburst),
        .m_axi_arvalid     (m_axi_arvalid),
        .m_axi_arready     (m_axi_arready),
        .m_axi_rdata       (m_axi_rdata),
        .m_axi_rresp       (m_axi_rresp),
        .m_axi_rlast       (m_axi_rlast),
        .m_axi_rvalid      (m_axi_rvalid),
        .m_axi_rready      (m_axi_rready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast)
    );

    int n_checks = 0;
    int n_errors = 0;

    // What the bus monitor saw during one transfer
    logic [31:0] obs_ar_addr[$];
    logic [7:0]  obs_ar_len[$];
    logic [31:0] obs_data[$];
    logic        obs_last[$];
    int          obs_int_cnt;
    int          obs_int_cycle;
    int          obs_idle_cycle;
    logic        obs_err_at_int;
    logic        obs_err_after_accept;
    logic        obs_idle_after_accept;
    bit          obs_timeout;
    int          viol_unstable;
    int          viol_multi;
    int          viol_pass;

    // Reference model results
    logic [31:0] exp_ar_addr[$];
    logic [7:0]  exp_ar_len[$];
    int          exp_beats;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Split the transfer into bursts: each takes as many beats as allowed by
    // what is left, the burst limit, and the distance to the next 4 KB page.
    function automatic void build_expected(input logic [31:0] sa, input logic [25:0] len);
        logic [31:0] a;
        int rem;
        exp_ar_addr.delete();
        exp_ar_len.delete();
        a = sa & 32'hFFFF_FFFC;
        rem = int'(len >> 2);
        exp_beats = rem;
        while (rem > 0) begin
            int page;
            int n;
            page = (4096 - int'(a % 32'd4096)) / 4;
            n = rem;
            if (n > MAX_BURST) n = MAX_BURST;
            if (n > page) n = page;
            exp_ar_addr.push_back(a);
            exp_ar_len.push_back(8'(n - 1));
            a = a + 32'(4 * n);
            rem = rem - n;
        end
    endfunction

    // Issues one request and plays the AXI read slave until the completion
    // pulse (plus a few cycles), or until reset is forced on beat abort_beat.
    task automatic run_transfer(input logic [31:0] sa, input logic [25:0] len, input bit stall,
                                input int err_beat, input int abort_beat, output bit aborted);
        bit          out;
        logic [31:0] s_addr;
        int          s_left;
        int          beat;
        bit          prev_stall;
        logic [31:0] prev_addr;
        logic [7:0]  prev_len;
        bit          int_seen;
        aborted = 1'b0;
        out = 1'b0; s_addr = 32'd0; s_left = 0; beat = 0;
        prev_stall = 1'b0; prev_addr = 32'd0; prev_len = 8'd0; int_seen = 1'b0;
        obs_ar_addr.delete(); obs_ar_len.delete(); obs_data.delete(); obs_last.delete();
        obs_int_cnt = 0; obs_int_cycle = -1; obs_idle_cycle = -1;
        obs_err_at_int = 1'bx; obs_err_after_accept = 1'bx; obs_idle_after_accept = 1'bx;
        obs_timeout = 1'b0; viol_unstable = 0; viol_multi = 0; viol_pass = 0;
        dma_sa_config = sa;
        dma_length_config = len;
        dma_read_valid = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1) begin
                dma_read_valid = 1'b0;
                dma_sa_config = $urandom;
                dma_length_config = 26'($urandom);
            end
            m_axi_arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axis_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_axi_rvalid  = out && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
            m_axi_rdata   = out ? mem_word(s_addr) : $urandom;
            m_axi_rresp   = (out && beat == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast   = out && (s_left == 1);
            @(negedge clk);
            if (cyc == 1) begin
                obs_idle_after_accept = dma_read_idle;
                obs_err_after_accept = dma_read_error;
            end
            if (m_axi_arvalid) begin
                if (out) viol_multi++;
                if (prev_stall && (m_axi_araddr !== prev_addr || m_axi_arlen !== prev_len)) viol_unstable++;
            end
            prev_stall = m_axi_arvalid && !m_axi_arready;
            prev_addr = m_axi_araddr;
            prev_len = m_axi_arlen;
            if (!out) begin
                if (m_axi_rready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) viol_pass++;
            end else if (m_axi_rready !== m_axis_tready || m_axis_tvalid !== m_axi_rvalid ||
                         (m_axi_rvalid && m_axis_tdata !== m_axi_rdata)) begin
                viol_pass++;
            end
            if (DMA_Read_INT === 1'b1) begin
                obs_int_cnt++;
                if (!int_seen) begin
                    int_seen = 1'b1;
                    obs_int_cycle = cyc;
                    obs_err_at_int = dma_read_error;
                end
            end
            if (int_seen && obs_idle_cycle < 0 && dma_read_idle === 1'b1) obs_idle_cycle = cyc;
            if (out && m_axi_rvalid && m_axi_rready) begin
                obs_data.push_back(m_axis_tdata);
                obs_last.push_back(m_axis_tlast);
                if (beat == abort_beat) begin
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    aborted = 1'b1;
                    return;
                end
                beat++;
                s_addr = s_addr + 32'd4;
                s_left--;
                if (s_left == 0) out = 1'b0;
            end else if (m_axi_arvalid && m_axi_arready) begin
                obs_ar_addr.push_back(m_axi_araddr);
                obs_ar_len.push_back(m_axi_arlen);
                out = 1'b1;
                s_addr = m_axi_araddr;
                s_left = int'(m_axi_arlen) + 1;
            end
            @(posedge clk);
            #1;
            if (int_seen && cyc >= obs_int_cycle + 3) break;
        end
        if (!int_seen) obs_timeout = 1'b1;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        m_axi_rresp = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dma_read_valid = 1'b1;
        dma_sa_config = 32'h1234_5678;
        dma_length_config = 26'h40;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axis_tready = 1'b1;
        m_axi_rdata = 32'd0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        dma_read_valid = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_arready = 1'b0;
        @(negedge clk);
        n_checks++; if (dma_read_idle !== 1'b1) begin n_errors++; $display("FAIL reset_idle: got %b want 1", dma_read_idle); end
        n_checks++; if (m_axi_arvalid !== 1'b0) begin n_errors++; $display("FAIL reset_arvalid: got %b want 0", m_axi_arvalid); end
        n_checks++; if (m_axi_rready !== 1'b0) begin n_errors++; $display("FAIL reset_rready: got %b want 0", m_axi_rready); end
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_checks++; if (m_axis_tlast !== 1'b0) begin n_errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        n_checks++; if (DMA_Read_INT !== 1'b0) begin n_errors++; $display("FAIL reset_int: got %b want 0", DMA_Read_INT); end
        n_checks++; if (dma_read_error !== 1'b0) begin n_errors++; $display("FAIL reset_error: got %b want 0", dma_read_error); end
        n_checks++; if (m_axi_araddr !== 32'd0) begin n_errors++; $display("FAIL reset_araddr: got %h want 0", m_axi_araddr); end
        n_checks++; if (m_axi_arlen !== 8'd0) begin n_errors++; $display("FAIL reset_arlen: got %0d want 0", m_axi_arlen); end
        n_checks++; if (m_axi_arsize !== 3'b010 || m_axi_arburst !== 2'b01) begin
            n_errors++; $display("FAIL const_size_burst: got %b/%b want 010/01", m_axi_arsize, m_axi_arburst); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_burst();
        bit ab;
        build_expected(32'h0, 26'h40);
        run_transfer(32'h0, 26'h40, 1'b0, -1, -1, ab);
        n_checks++; if (obs_timeout) begin n_errors++; $display("FAIL single_timeout: got no INT want INT"); end
        n_checks++; if (obs_ar_addr.size() != 1) begin n_errors++; $display("FAIL single_ar_count: got %0d want 1", obs_ar_addr.size()); end
        n_checks++; if (obs_ar_addr[0] !== 32'h0 || obs_ar_len[0] !== 8'd15) begin
            n_errors++; $display("FAIL single_ar: got %h/%0d want 0/15", obs_ar_addr[0], obs_ar_len[0]); end
        n_checks++; if (obs_data.size() != 16) begin n_errors++; $display("FAIL single_beats: got %0d want 16", obs_data.size()); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (k >= obs_data.size() || obs_data[k] !== mem_word(32'(4 * k)) || obs_last[k] !== (k == 15)) begin
                n_errors++; $display("FAIL single_beat%0d: got %h last=%b want %h last=%b", k,
                    (k < obs_data.size()) ? obs_data[k] : 32'hx, (k < obs_last.size()) ? obs_last[k] : 1'bx,
                    mem_word(32'(4 * k)), (k == 15));
            end
        end
        n_checks++; if (obs_int_cnt != 1) begin n_errors++; $display("FAIL single_int_count: got %0d want 1", obs_int_cnt); end
        n_checks++; if (obs_err_at_int !== 1'b0) begin n_errors++; $display("FAIL single_error: got %b want 0", obs_err_at_int); end
        n_checks++; if (viol_pass != 0) begin n_errors++; $display("FAIL single_passthrough: got %0d violations want 0", viol_pass); end
    endtask

    task automatic test_4k_cross();
        bit ab;
        run_transfer(32'h0000_0FF0, 26'h20, 1'b0, -1, -1, ab);
        n_checks++; if (obs_ar_addr.size() != 2) begin n_errors++; $display("FAIL cross_ar_count: got %0d want 2", obs_ar_addr.size()); end
        n_checks++; if (obs_ar_addr[0] !== 32'h0FF0 || obs_ar_len[0] !== 8'd3) begin
            n_errors++; $display("FAIL cross_ar0: got %h/%0d want ff0/3", obs_ar_addr[0], obs_ar_len[0]); end
        n_checks++; if (obs_ar_addr[1] !== 32'h1000 || obs_ar_len[1] !== 8'd3) begin
            n_errors++; $display("FAIL cross_ar1: got %h/%0d want 1000/3", obs_ar_addr[1], obs_ar_len[1]); end
        n_checks++; if (obs_data.size() != 8) begin n_errors++; $display("FAIL cross_beats: got %0d want 8", obs_data.size()); end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (k >= obs_data.size() || obs_data[k] !== mem_word(32'h0FF0 + 32'(4 * k)) || obs_last[k] !== (k == 7)) begin
                n_errors++; $display("FAIL cross_beat%0d: got %h last=%b want %h last=%b", k,
                    (k < obs_data.size()) ? obs_data[k] : 32'hx, (k < obs_last.size()) ? obs_last[k] : 1'bx,
                    mem_word(32'h0FF0 + 32'(4 * k)), (k == 7));
            end
        end
        n_checks++; if (obs_int_cnt != 1) begin n_errors++; $display("FAIL cross_int_count: got %0d want 1", obs_int_cnt); end
    endtask

    task automatic test_zero_length();
        bit ab;
        logic [25:0] lens[2];
        lens[0] = 26'h0;
        lens[1] = 26'h3;
        for (int i = 0; i < 2; i++) begin
            run_transfer(32'h0000_8000, lens[i], 1'b0, -1, -1, ab);
            n_checks++; if (obs_ar_addr.size() != 0) begin n_errors++; $display("FAIL zero%0d_ar_count: got %0d want 0", i, obs_ar_addr.size()); end
            n_checks++; if (obs_int_cycle != 1 || obs_int_cnt != 1) begin
                n_errors++; $display("FAIL zero%0d_int: got cycle %0d count %0d want cycle 1 count 1", i, obs_int_cycle, obs_int_cnt); end
            n_checks++; if (obs_idle_after_accept !== 1'b0) begin n_errors++; $display("FAIL zero%0d_idle_in_done: got %b want 0", i, obs_idle_after_accept); end
            n_checks++; if (obs_idle_cycle != 2) begin n_errors++; $display("FAIL zero%0d_idle_return: got cycle %0d want 2", i, obs_idle_cycle); end
        end
    endtask

    task automatic test_random_stalls();
        logic [31:0] sa_list[8];
        logic [25:0] len_list[8];
        bit ab;
        sa_list[0] = 32'h0001_2000; len_list[0] = 26'h100;
        sa_list[1] = 32'hFFFF_FFC0; len_list[1] = 26'h080;
        for (int i = 2; i < 8; i++) begin
            sa_list[i] = $urandom;
            len_list[i] = 26'($urandom_range(0, 1023));
        end
        for (int t = 0; t < 8; t++) begin
            logic [31:0] base;
            base = sa_list[t] & 32'hFFFF_FFFC;
            build_expected(sa_list[t], len_list[t]);
            run_transfer(sa_list[t], len_list[t], 1'b1, -1, -1, ab);
            n_checks++; if (obs_timeout) begin n_errors++; $display("FAIL rand%0d_timeout: got no INT want INT", t); end
            n_checks++; if (obs_ar_addr.size() != exp_ar_addr.size()) begin
                n_errors++; $display("FAIL rand%0d_ar_count: got %0d want %0d", t, obs_ar_addr.size(), exp_ar_addr.size()); end
            for (int b = 0; b < exp_ar_addr.size(); b++) begin
                n_checks++;
                if (b >= obs_ar_addr.size() || obs_ar_addr[b] !== exp_ar_addr[b] || obs_ar_len[b] !== exp_ar_len[b]) begin
                    n_errors++; $display("FAIL rand%0d_ar%0d: got %h/%0d want %h/%0d", t, b,
                        (b < obs_ar_addr.size()) ? obs_ar_addr[b] : 32'hx, (b < obs_ar_len.size()) ? obs_ar_len[b] : 8'hx,
                        exp_ar_addr[b], exp_ar_len[b]);
                end
            end
            n_checks++; if (obs_data.size() != exp_beats) begin
                n_errors++; $display("FAIL rand%0d_beats: got %0d want %0d", t, obs_data.size(), exp_beats); end
            for (int k = 0; k < exp_beats; k++) begin
                n_checks++;
                if (k >= obs_data.size() || obs_data[k] !== mem_word(base + 32'(4 * k)) || obs_last[k] !== (k == exp_beats - 1)) begin
                    n_errors++; $display("FAIL rand%0d_beat%0d: got %h last=%b want %h last=%b", t, k,
                        (k < obs_data.size()) ? obs_data[k] : 32'hx, (k < obs_last.size()) ? obs_last[k] : 1'bx,
                        mem_word(base + 32'(4 * k)), (k == exp_beats - 1));
                end
            end
            n_checks++; if (obs_int_cnt != 1) begin n_errors++; $display("FAIL rand%0d_int_count: got %0d want 1", t, obs_int_cnt); end
            n_checks++; if (viol_unstable != 0 || viol_multi != 0) begin
                n_errors++; $display("FAIL rand%0d_ar_protocol: got unstable=%0d multi=%0d want 0/0", t, viol_unstable, viol_multi); end
            n_checks++; if (viol_pass != 0) begin n_errors++; $display("FAIL rand%0d_passthrough: got %0d violations want 0", t, viol_pass); end
            n_checks++; if (obs_err_at_int !== 1'b0) begin n_errors++; $display("FAIL rand%0d_error: got %b want 0", t, obs_err_at_int); end
        end
    endtask

    task automatic test_rresp_error();
        bit ab;
        run_transfer(32'h0000_0400, 26'h40, 1'b0, 2, -1, ab);
        n_checks++; if (obs_data.size() != 16) begin n_errors++; $display("FAIL err_beats: got %0d want 16", obs_data.size()); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (k >= obs_data.size() || obs_data[k] !== mem_word(32'h400 + 32'(4 * k))) begin
                n_errors++; $display("FAIL err_beat%0d: got %h want %h", k,
                    (k < obs_data.size()) ? obs_data[k] : 32'hx, mem_word(32'h400 + 32'(4 * k)));
            end
        end
        n_checks++; if (obs_err_at_int !== 1'b1) begin n_errors++; $display("FAIL err_flag_at_int: got %b want 1", obs_err_at_int); end
        @(negedge clk);
        n_checks++; if (dma_read_error !== 1'b1) begin n_errors++; $display("FAIL err_sticky_idle: got %b want 1", dma_read_error); end
        @(posedge clk);
        #1;
        run_transfer(32'h0000_0100, 26'h10, 1'b0, -1, -1, ab);
        n_checks++; if (obs_err_after_accept !== 1'b0) begin n_errors++; $display("FAIL err_cleared: got %b want 0", obs_err_after_accept); end
        n_checks++; if (obs_err_at_int !== 1'b0 || obs_int_cnt != 1) begin
            n_errors++; $display("FAIL err_next_clean: got err=%b ints=%0d want 0/1", obs_err_at_int, obs_int_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        bit ab;
        int ints;
        run_transfer(32'h0000_3000, 26'h40, 1'b0, -1, 4, ab);
        n_checks++; if (!ab) begin n_errors++; $display("FAIL abort_reached: got no beat 5 want beat 5"); end
        m_axi_rvalid = 1'b1;
        m_axis_tready = 1'b1;
        m_axi_arready = 1'b0;
        @(negedge clk);
        n_checks++; if (dma_read_idle !== 1'b1) begin n_errors++; $display("FAIL abort_idle: got %b want 1", dma_read_idle); end
        n_checks++; if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            n_errors++; $display("FAIL abort_valids: got ar=%b r=%b t=%b l=%b want 0000",
                m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast); end
        ints = 0;
        for (int c = 0; c < 20; c++) begin
            if (DMA_Read_INT === 1'b1) ints++;
            @(negedge clk);
        end
        n_checks++; if (ints != 0) begin n_errors++; $display("FAIL abort_no_int: got %0d pulses want 0", ints); end
        m_axi_rvalid = 1'b0;
        @(posedge clk);
        #1;
        run_transfer(32'h0000_3000, 26'h40, 1'b0, -1, -1, ab);
        n_checks++; if (obs_ar_addr.size() != 1 || obs_ar_addr[0] !== 32'h3000 || obs_ar_len[0] !== 8'd15) begin
            n_errors++; $display("FAIL abort_retry_ar: got count %0d addr %h len %0d want 1/3000/15",
                obs_ar_addr.size(), obs_ar_addr[0], obs_ar_len[0]); end
        n_checks++; if (obs_data.size() != 16 || obs_int_cnt != 1) begin
            n_errors++; $display("FAIL abort_retry_done: got beats %0d ints %0d want 16/1", obs_data.size(), obs_int_cnt); end
        n_checks++; if (obs_data[15] !== mem_word(32'h303C) || obs_last[15] !== 1'b1) begin
            n_errors++; $display("FAIL abort_retry_last: got %h last=%b want %h last=1", obs_data[15], obs_last[15], mem_word(32'h303C)); end
    endtask

    initial begin
        rst = 1'b1;
        dma_read_valid = 1'b0;
        dma_sa_config = 32'd0;
        dma_length_config = 26'd0;
        m_axi_arready = 1'b0;
        m_axi_rdata = 32'd0;
        m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axis_tready = 1'b0;
        test_reset();
        test_single_burst();
        test_4k_cross();
        test_zero_length();
        test_random_stalls();
        test_rresp_error();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
